// File: rtl/f1_start_ctrl.sv
// F1 start-light sequencing controller: build-up/hold advance pulses, reaction timing, jump-start flag.
// Optional F1_JUMP_ABORT_EN: a react event during the hold forces lights-out and returns to idle.
module f1_start_ctrl #(
  parameter int unsigned TICK_N = 48,
  parameter int unsigned RW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_seq,
  input  logic          cmd_delay,
  input  logic          react,
  output logic          en,
  output logic          busy,
  output logic [RW-1:0] react_time,
  output logic          react_valid,
  output logic          jump_start
);

  localparam int unsigned PW = (TICK_N > 2) ? $clog2(TICK_N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEQ,
    ST_DELAY,
    ST_TIMING
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [6:0]    r_lfsr;
  logic [6:0]    r_dly;
  logic [RW-1:0] r_cnt;
  logic          r_react_q;
  logic [RW-1:0] r_react_time;
  logic          r_react_valid;
  logic          r_jump;

  logic w_tick;
  logic w_react_ev;
  logic w_cnt_last;
  logic w_en;
  logic w_dly_load;
  logic w_dly_dec;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_meas;
  logic w_timeout;
  logic w_jump_set;
  logic w_jump_clr;

  assign w_tick     = (r_presc == PW'(TICK_N - 1));
  assign w_react_ev = react & ~r_react_q;
  // One increment away from the all-ones timeout value.
  assign w_cnt_last = (&r_cnt[RW-1:1]) & ~r_cnt[0];

  always_comb begin
    w_state_nxt = r_state;
    w_en        = 1'b0;
    w_dly_load  = 1'b0;
    w_dly_dec   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_meas      = 1'b0;
    w_timeout   = 1'b0;
    w_jump_set  = 1'b0;
    w_jump_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_seq) begin
          w_state_nxt = ST_SEQ;
          w_jump_clr  = 1'b1;
        end
      end
      ST_SEQ: begin
        w_en       = w_tick;
        w_jump_set = w_react_ev;
        if (cmd_delay) begin
          w_state_nxt = ST_DELAY;
          w_dly_load  = 1'b1;
        end else if (!cmd_seq) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DELAY: begin
        w_jump_set = w_react_ev;
`ifdef F1_JUMP_ABORT_EN
        if (w_react_ev) begin
          w_en        = 1'b1;
          w_state_nxt = ST_IDLE;
        end else
`endif
        if (w_tick) begin
          if (r_dly == 7'd1) begin
            w_en        = 1'b1;
            w_state_nxt = ST_TIMING;
            w_cnt_clr   = 1'b1;
          end else begin
            w_dly_dec = 1'b1;
          end
        end
      end
      ST_TIMING: begin
        // A press on a tick cycle reports the count before that tick.
        if (w_react_ev) begin
          w_meas      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          w_cnt_inc = 1'b1;
          if (w_cnt_last) begin
            w_timeout   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_presc       <= '0;
      r_lfsr        <= 7'b0000001;
      r_dly         <= '0;
      r_cnt         <= '0;
      r_react_q     <= 1'b0;
      r_react_time  <= '0;
      r_react_valid <= 1'b0;
      r_jump        <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_react_q <= react;
      r_lfsr    <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};

      // Restarting on every state change aligns the first tick to state entry.
      if (w_state_nxt != r_state || w_tick) r_presc <= '0;
      else                                   r_presc <= r_presc + 1'b1;

      if (w_dly_load)     r_dly <= r_lfsr;
      else if (w_dly_dec) r_dly <= r_dly - 1'b1;

      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;

      if (w_meas)         r_react_time <= r_cnt;
      else if (w_timeout) r_react_time <= '1;
      r_react_valid <= w_meas | w_timeout;

      if (w_jump_clr)      r_jump <= 1'b0;
      else if (w_jump_set) r_jump <= 1'b1;
    end
  end

  assign en          = w_en;
  assign busy        = (r_state != ST_IDLE);
  assign react_time  = r_react_time;
  assign react_valid = r_react_valid;
  assign jump_start  = r_jump;

endmodule
